// File: rtl/bpred_pkg.sv
// rtl/bpred_pkg.sv - shared types and helpers for the branch resolution queue
package bpred_pkg;

  localparam int BPRED_WIDTH_DEFAULT = 10;

  typedef struct packed {
    logic [BPRED_WIDTH_DEFAULT-1:0] index;
    logic                           prediction;
    logic [BPRED_WIDTH_DEFAULT-1:0] ghr_snapshot;
  } bpq_entry_t;

  // GHR as it should have been: pre-branch history shifted with the real outcome.
  function automatic logic [BPRED_WIDTH_DEFAULT-1:0] restore_ghr(
    input logic [BPRED_WIDTH_DEFAULT-1:0] snapshot,
    input logic                           outcome
  );
    return {snapshot[BPRED_WIDTH_DEFAULT-2:0], outcome};
  endfunction

endpackage

// File: rtl/bpq_storage.sv
// rtl/bpq_storage.sv - in-flight branch entry register file, one write port, async read
module bpq_storage
  import bpred_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int PTR_WIDTH = 2
) (
  input  logic                 i_Clk,
  input  logic                 i_Wr_En,
  input  logic [PTR_WIDTH-1:0] i_Wr_Ptr,
  input  bpq_entry_t           i_Wr_Data,
  input  logic [PTR_WIDTH-1:0] i_Rd_Ptr,
  output bpq_entry_t           o_Rd_Data
);

  bpq_entry_t mem_q [DEPTH];
  bpq_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (i_Wr_En) begin
      mem_d[i_Wr_Ptr] = i_Wr_Data;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge i_Clk) begin
    mem_q <= mem_d;
  end

  assign o_Rd_Data = mem_q[i_Rd_Ptr];

endmodule

// File: rtl/branch_resolution_queue.sv
// rtl/branch_resolution_queue.sv - in-order match of DEC predictions against EX outcomes
module branch_resolution_queue
  import bpred_pkg::*;
#(
  parameter int BPRED_WIDTH = BPRED_WIDTH_DEFAULT,
  parameter int DEPTH       = 4,
  parameter int PTR_WIDTH   = 2
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_DEC_Is_Branch,
  input  logic [BPRED_WIDTH-1:0] i_Pred_Index,
  input  logic                   i_Prediction,
  input  logic [BPRED_WIDTH-1:0] i_GHR_Snapshot,
  input  logic                   i_ALU_Branch_Valid,
  input  logic                   i_ALU_Branch_Outcome,
  input  logic                   i_Flush,
  output logic                   o_Full,
  output logic                   o_Empty,
  output logic                   o_Update_Valid,
  output logic [BPRED_WIDTH-1:0] o_Resolution_Index,
  output logic                   o_Update_Outcome,
  output logic                   o_Mispredict,
  output logic [BPRED_WIDTH-1:0] o_GHR_Restore,
  output logic                   o_Underflow
);

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0]   head_q, head_d, tail_q, tail_d;
  logic [PTR_WIDTH:0]     count_q, count_d;
  logic                   update_valid_q, update_valid_d;
  logic [BPRED_WIDTH-1:0] res_index_q, res_index_d;
  logic                   update_outcome_q, update_outcome_d;
  logic                   mispredict_q, mispredict_d;
  logic [BPRED_WIDTH-1:0] ghr_restore_q, ghr_restore_d;
  logic                   underflow_q, underflow_d;

  logic       pop_accept, push_accept, mispredict_now, flush_now;
  bpq_entry_t wr_entry, head_entry;

  assign o_Full  = (count_q == FULL_COUNT);
  assign o_Empty = (count_q == '0);

  assign wr_entry = '{index: i_Pred_Index, prediction: i_Prediction, ghr_snapshot: i_GHR_Snapshot};

  bpq_storage #(
    .DEPTH     (DEPTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_storage (
    .i_Clk     (i_Clk),
    .i_Wr_En   (push_accept),
    .i_Wr_Ptr  (tail_q),
    .i_Wr_Data (wr_entry),
    .i_Rd_Ptr  (head_q),
    .o_Rd_Data (head_entry)
  );

  always_comb begin
    pop_accept     = i_ALU_Branch_Valid && !o_Empty;
    mispredict_now = pop_accept && (head_entry.prediction != i_ALU_Branch_Outcome);
    // A mispredict discards everything younger, exactly like an external flush.
    flush_now      = i_Flush || mispredict_now;
    push_accept    = i_DEC_Is_Branch && (!o_Full || pop_accept) && !flush_now;

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_now) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop_accept)  head_d = head_q + PTR_ONE;
      if (push_accept) tail_d = tail_q + PTR_ONE;
      unique case ({push_accept, pop_accept})
        2'b10:   count_d = count_q + COUNT_ONE;
        2'b01:   count_d = count_q - COUNT_ONE;
        default: count_d = count_q;
      endcase
    end

    underflow_d      = underflow_q || (i_ALU_Branch_Valid && o_Empty);
    update_valid_d   = pop_accept;
    res_index_d      = pop_accept ? head_entry.index : res_index_q;
    update_outcome_d = pop_accept ? i_ALU_Branch_Outcome : update_outcome_q;
    mispredict_d     = mispredict_now;
    ghr_restore_d    = mispredict_now ? restore_ghr(head_entry.ghr_snapshot, i_ALU_Branch_Outcome)
                                      : ghr_restore_q;
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      update_valid_q   <= 1'b0;
      res_index_q      <= '0;
      update_outcome_q <= 1'b0;
      mispredict_q     <= 1'b0;
      ghr_restore_q    <= '0;
      underflow_q      <= 1'b0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      count_q          <= count_d;
      update_valid_q   <= update_valid_d;
      res_index_q      <= res_index_d;
      update_outcome_q <= update_outcome_d;
      mispredict_q     <= mispredict_d;
      ghr_restore_q    <= ghr_restore_d;
      underflow_q      <= underflow_d;
    end
  end

  assign o_Update_Valid     = update_valid_q;
  assign o_Resolution_Index = res_index_q;
  assign o_Update_Outcome   = update_outcome_q;
  assign o_Mispredict       = mispredict_q;
  assign o_GHR_Restore      = ghr_restore_q;
  assign o_Underflow        = underflow_q;

endmodule

// File: tb/tb_branch_resolution_queue.sv
// tb/tb_branch_resolution_queue.sv - directed vector bench for branch_resolution_queue
module tb_branch_resolution_queue;

  typedef struct packed {
    logic       rst;
    logic       br;
    logic [9:0] idx;
    logic       pred;
    logic [9:0] snap;
    logic       av;
    logic       ao;
    logic       fl;
  } in_t;

  typedef struct packed {
    logic       full;
    logic       empty;
    logic       uv;
    logic [9:0] idx;
    logic       uo;
    logic       mp;
    logic [9:0] ghr;
    logic       uf;
  } out_t;

  typedef struct {
    string name;
    in_t   stim;
    out_t  exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       br = 1'b0;
  logic [9:0] idx = '0;
  logic       pred = 1'b0;
  logic [9:0] snap = '0;
  logic       av = 1'b0;
  logic       ao = 1'b0;
  logic       fl = 1'b0;

  logic       full, empty, uv, uo, mp, uf;
  logic [9:0] res_idx, ghr;

  int n_vec = 0;
  int n_miss = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  branch_resolution_queue dut (
    .i_Clk                (clk),
    .i_Reset              (rst),
    .i_DEC_Is_Branch      (br),
    .i_Pred_Index         (idx),
    .i_Prediction         (pred),
    .i_GHR_Snapshot       (snap),
    .i_ALU_Branch_Valid   (av),
    .i_ALU_Branch_Outcome (ao),
    .i_Flush              (fl),
    .o_Full               (full),
    .o_Empty              (empty),
    .o_Update_Valid       (uv),
    .o_Resolution_Index   (res_idx),
    .o_Update_Outcome     (uo),
    .o_Mispredict         (mp),
    .o_GHR_Restore        (ghr),
    .o_Underflow          (uf)
  );

  function automatic in_t fi(logic r, logic b, logic [9:0] i, logic p, logic [9:0] s,
                             logic v, logic o, logic f);
    in_t t;
    t = '{rst: r, br: b, idx: i, pred: p, snap: s, av: v, ao: o, fl: f};
    return t;
  endfunction

  function automatic out_t fo(logic fu, logic em, logic u, logic [9:0] i, logic o,
                              logic m, logic [9:0] g, logic f);
    out_t t;
    t = '{full: fu, empty: em, uv: u, idx: i, uo: o, mp: m, ghr: g, uf: f};
    return t;
  endfunction

  function automatic void add(string n, in_t s, out_t e);
    vec_t v;
    v.name = n;
    v.stim = s;
    v.exp  = e;
    vecs.push_back(v);
  endfunction

  task automatic apply_and_check(string n, in_t s, out_t e);
    out_t act;
    @(negedge clk);
    rst  = s.rst;  br = s.br;   idx = s.idx; pred = s.pred;
    snap = s.snap; av = s.av;   ao  = s.ao;  fl   = s.fl;
    @(posedge clk);
    #1;
    act = '{full: full, empty: empty, uv: uv, idx: res_idx, uo: uo, mp: mp, ghr: ghr, uf: uf};
    n_vec++;
    if (act !== e) begin
      n_miss++;
      $display("FAIL %s: got full=%b empty=%b uv=%b idx=%h uo=%b mp=%b ghr=%h uf=%b, want full=%b empty=%b uv=%b idx=%h uo=%b mp=%b ghr=%h uf=%b",
               n, act.full, act.empty, act.uv, act.idx, act.uo, act.mp, act.ghr, act.uf,
               e.full, e.empty, e.uv, e.idx, e.uo, e.mp, e.ghr, e.uf);
    end
  endtask

  initial begin
    in_t idle;
    idle = fi(0, 0, 10'h0, 0, 10'h0, 0, 0, 0);

    add("reset", fi(1, 0, 10'h0, 0, 10'h0, 0, 0, 0), fo(0, 1, 0, 10'h000, 0, 0, 10'h000, 0));
    for (int i = 0; i < 10; i++) add("idle_after_reset", idle, fo(0, 1, 0, 10'h000, 0, 0, 10'h000, 0));

    add("push_155",   fi(0, 1, 10'h155, 1, 10'h0AA, 0, 0, 0), fo(0, 0, 0, 10'h000, 0, 0, 10'h000, 0));
    add("pop_155_ok", fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 1, 1, 10'h155, 1, 0, 10'h000, 0));
    add("pulse_drop", idle,                                   fo(0, 1, 0, 10'h155, 1, 0, 10'h000, 0));

    add("push_020",   fi(0, 1, 10'h020, 0, 10'h3FF, 0, 0, 0), fo(0, 0, 0, 10'h155, 1, 0, 10'h000, 0));
    add("push_021",   fi(0, 1, 10'h021, 1, 10'h001, 0, 0, 0), fo(0, 0, 0, 10'h155, 1, 0, 10'h000, 0));
    add("push_022",   fi(0, 1, 10'h022, 1, 10'h002, 0, 0, 0), fo(0, 0, 0, 10'h155, 1, 0, 10'h000, 0));
    add("mispred_020",fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 1, 1, 10'h020, 1, 1, 10'h3FF, 0));
    add("after_misp", idle,                                   fo(0, 1, 0, 10'h020, 1, 0, 10'h3FF, 0));

    add("fill_100",   fi(0, 1, 10'h100, 1, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h020, 1, 0, 10'h3FF, 0));
    add("fill_101",   fi(0, 1, 10'h101, 1, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h020, 1, 0, 10'h3FF, 0));
    add("fill_102",   fi(0, 1, 10'h102, 1, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h020, 1, 0, 10'h3FF, 0));
    add("fill_103",   fi(0, 1, 10'h103, 1, 10'h000, 0, 0, 0), fo(1, 0, 0, 10'h020, 1, 0, 10'h3FF, 0));
    add("push_full",  fi(0, 1, 10'h1FF, 1, 10'h000, 0, 0, 0), fo(1, 0, 0, 10'h020, 1, 0, 10'h3FF, 0));
    add("pushpop_full",fi(0, 1, 10'h104, 1, 10'h000, 1, 1, 0), fo(1, 0, 1, 10'h100, 1, 0, 10'h3FF, 0));
    add("drain_101",  fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 0, 1, 10'h101, 1, 0, 10'h3FF, 0));
    add("drain_102",  fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 0, 1, 10'h102, 1, 0, 10'h3FF, 0));
    add("drain_103",  fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 0, 1, 10'h103, 1, 0, 10'h3FF, 0));
    add("drain_104",  fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 1, 1, 10'h104, 1, 0, 10'h3FF, 0));

    add("push_110",   fi(0, 1, 10'h110, 0, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h104, 1, 0, 10'h3FF, 0));
    add("pushpop_c1", fi(0, 1, 10'h111, 0, 10'h000, 1, 0, 0), fo(0, 0, 1, 10'h110, 0, 0, 10'h3FF, 0));
    add("pop_111",    fi(0, 0, 10'h000, 0, 10'h000, 1, 0, 0), fo(0, 1, 1, 10'h111, 0, 0, 10'h3FF, 0));

    add("push_120",   fi(0, 1, 10'h120, 1, 10'h155, 0, 0, 0), fo(0, 0, 0, 10'h111, 0, 0, 10'h3FF, 0));
    add("misp_drop_push", fi(0, 1, 10'h121, 1, 10'h000, 1, 0, 0), fo(0, 1, 1, 10'h120, 0, 1, 10'h2AA, 0));
    add("after_misp2",idle,                                   fo(0, 1, 0, 10'h120, 0, 0, 10'h2AA, 0));

    add("push_130",   fi(0, 1, 10'h130, 1, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h120, 0, 0, 10'h2AA, 0));
    add("push_131",   fi(0, 1, 10'h131, 1, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h120, 0, 0, 10'h2AA, 0));
    add("flush_push", fi(0, 1, 10'h132, 1, 10'h000, 0, 0, 1), fo(0, 1, 0, 10'h120, 0, 0, 10'h2AA, 0));
    add("after_flush",idle,                                   fo(0, 1, 0, 10'h120, 0, 0, 10'h2AA, 0));
    add("push_140",   fi(0, 1, 10'h140, 1, 10'h3C3, 0, 0, 0), fo(0, 0, 0, 10'h120, 0, 0, 10'h2AA, 0));
    add("flush_pop",  fi(0, 0, 10'h000, 0, 10'h000, 1, 0, 1), fo(0, 1, 1, 10'h140, 0, 1, 10'h386, 0));

    add("underflow",  fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 1, 0, 10'h140, 0, 0, 10'h386, 1));
    add("uf_sticky",  idle,                                   fo(0, 1, 0, 10'h140, 0, 0, 10'h386, 1));
    add("push_150",   fi(0, 1, 10'h150, 1, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h140, 0, 0, 10'h386, 1));
    add("pop_150",    fi(0, 0, 10'h000, 0, 10'h000, 1, 1, 0), fo(0, 1, 1, 10'h150, 1, 0, 10'h386, 1));
    add("push_160",   fi(0, 1, 10'h160, 0, 10'h000, 0, 0, 0), fo(0, 0, 0, 10'h150, 1, 0, 10'h386, 1));
    add("reset_mid",  fi(1, 1, 10'h161, 0, 10'h000, 0, 0, 0), fo(0, 1, 0, 10'h000, 0, 0, 10'h000, 0));
    add("after_reset",idle,                                   fo(0, 1, 0, 10'h000, 0, 0, 10'h000, 0));

    foreach (vecs[i]) apply_and_check(vecs[i].name, vecs[i].stim, vecs[i].exp);

    // Streaming one-in/one-out across nine branches walks both pointers around twice.
    for (int k = 0; k <= 9; k++) begin
      logic [9:0] kv, pv;
      kv = 10'(k);
      pv = 10'(k - 1);
      apply_and_check($sformatf("stream_%0d", k),
                      fi(0, k < 9, kv, kv[0], 10'h000, k > 0, pv[0], 0),
                      (k == 0) ? fo(0, 0, 0, 10'h000, 0, 0, 10'h000, 0)
                               : fo(0, k == 9, 1, pv, pv[0], 0, 10'h000, 0));
    end

    apply_and_check("stream_idle", idle, fo(0, 1, 0, 10'h008, 0, 0, 10'h000, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
